port_pkt_tx: RTL and testbench

//  Synthesizable per-port packet transmitter for the write side of the hydra switch.

---
 rtl/port_pkt_tx_if.sv | 26 ++
 rtl/port_pkt_tx.sv | 159 +++++++++++++++
 tb/tb_port_pkt_tx.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/port_pkt_tx_if.sv
// Descriptor and frame-write signal bundle for one switch write port.
// master drives descriptors and pause; slave is the transmitter.
interface port_pkt_tx_if;
    // Descriptor handshake: a descriptor transfers on a rising clk edge where
    // desc_vld and desc_rdy are both 1. Frame outputs have no ready; pause only gates frame starts.
    logic        desc_vld;
    logic [8:0]  desc_len;
    logic [2:0]  desc_prior;
    logic [3:0]  desc_dest;
    logic        desc_rdy;
    logic        pause;
    logic        wr_sop;
    logic        wr_vld;
    logic [15:0] wr_data;
    logic        wr_eop;

    modport master (
        output desc_vld, desc_len, desc_prior, desc_dest, pause,
        input  desc_rdy, wr_sop, wr_vld, wr_data, wr_eop
    );

    modport slave (
        input  desc_vld, desc_len, desc_prior, desc_dest, pause,
        output desc_rdy, wr_sop, wr_vld, wr_data, wr_eop
    );
endinterface

// File: rtl/port_pkt_tx.sv
// Per-port packet transmitter: descriptor FIFO feeding a SOP/HDR/DATA/EOP frame generator.
// Build option TX_PAYLOAD_LFSR_EN: payload from a 16-bit LFSR instead of an incrementing count.
module port_pkt_tx #(
    parameter int DESC_DEPTH = 4,
    parameter int LEN_MIN    = 31,
    parameter int LEN_MAX    = 511
) (
    input  logic         clk,
    input  logic         rst_n,
    port_pkt_tx_if.slave bus,
    output logic         busy,
    output logic [15:0]  pkt_cnt,
    output logic [7:0]   drop_cnt,
    output logic [2:0]   dbg_state
);
    localparam int         PW   = $clog2(DESC_DEPTH);
    localparam logic [8:0] LMIN = 9'(LEN_MIN);
    localparam logic [8:0] LMAX = 9'(LEN_MAX);
    localparam logic [PW:0] FULL = (PW+1)'(DESC_DEPTH);

    typedef enum logic [2:0] {ST_IDLE, ST_SOP, ST_HDR, ST_DATA, ST_EOP} state_e;
    state_e state_q, state_d;

    // Entries are packed {dest, prior, len}, which is also the LFSR seed order.
    logic [15:0]   mem_q [DESC_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push, pop, drop, head_legal;
    logic [15:0]   head;
    logic [15:0]   cur_q, cur_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [15:0]   payload;
    logic          sop_q, sop_d, vld_q, vld_d, eop_q, eop_d;
    logic [15:0]   data_q, data_d;
    logic [15:0]   pkt_cnt_q;
    logic [7:0]    drop_cnt_q;

    assign bus.desc_rdy = (count_q != FULL);
    assign push         = bus.desc_vld && bus.desc_rdy;
    assign head         = mem_q[rd_ptr_q];
    assign head_legal   = (head[8:0] >= LMIN) && (head[8:0] <= LMAX);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.desc_dest, bus.desc_prior, bus.desc_len};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef TX_PAYLOAD_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == ST_SOP)
            lfsr_d = (cur_q == 16'h0000) ? 16'h0001 : cur_q;
        else if (state_q == ST_DATA)
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'h0001;
        else        lfsr_q <= lfsr_d;
    end

    assign payload = lfsr_q;
`else
    assign payload = {7'd0, cnt_q};
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        drop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0 && !bus.pause) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        cur_d   = head;
                        state_d = ST_SOP;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_SOP: begin
                cnt_d   = '0;
                state_d = ST_HDR;
            end
            ST_HDR:  state_d = ST_DATA;
            ST_DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == cur_q[8:0] - 9'd1) state_d = ST_EOP;
            end
            ST_EOP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame outputs are a registered image of the current state, one cycle behind it.
    always_comb begin
        sop_d  = (state_q == ST_SOP);
        vld_d  = (state_q == ST_HDR) || (state_q == ST_DATA);
        eop_d  = (state_q == ST_EOP);
        data_d = 16'h0000;
        if (state_q == ST_HDR)       data_d = {cur_q[8:0], cur_q[11:9], cur_q[15:12]};
        else if (state_q == ST_DATA) data_d = payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            cnt_q      <= '0;
            sop_q      <= 1'b0;
            vld_q      <= 1'b0;
            eop_q      <= 1'b0;
            data_q     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
            vld_q   <= vld_d;
            eop_q   <= eop_d;
            data_q  <= data_d;
            if (state_q == ST_EOP)            pkt_cnt_q  <= pkt_cnt_q + 16'd1;
            if (drop && drop_cnt_q != 8'hFF)  drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.wr_sop  = sop_q;
    assign bus.wr_vld  = vld_q;
    assign bus.wr_eop  = eop_q;
    assign bus.wr_data = data_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign dbg_state   = state_q;
    // The trailing registered output cycle still counts as busy.
    assign busy = (state_q != ST_IDLE) || (count_q != '0) || sop_q || vld_q || eop_q;
endmodule

// File: tb/tb_port_pkt_tx.sv
// Bench for port_pkt_tx: directed scenarios plus randomized descriptors and pause,
// checked against a frame-level scoreboard built from each accepted descriptor.
module tb_port_pkt_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [7:0]  drop_cnt;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    port_pkt_tx_if bus();

    port_pkt_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    int          exp_len_q[$];
    int          exp_frames = 0;
    int          exp_drops  = 0;

    int  sop_count = 0, eop_count = 0, nwords = 0, ncyc = 0;
    int  last_eop_cyc = 0, sop_cyc = 0, cur_len = 0;
    bit  in_frame = 1'b0, have_eop = 1'b0;
    time last_push_t = 0, last_sop_t = 0, last_eop_t = 0;
    bit  rand_pause_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Expected frame: header then len payload words, only for legal lengths.
    task automatic model_push(input logic [8:0] len, input logic [2:0] pr, input logic [3:0] de);
        logic [15:0] s;
        if (len >= 9'd31) begin
            exp_frames++;
            exp_len_q.push_back(int'(len));
            exp_q.push_back({len, pr, de});
            s = {de, pr, len};
            if (s == 16'h0000) s = 16'h0001;
            for (int k = 0; k < int'(len); k++) begin
`ifdef TX_PAYLOAD_LFSR_EN
                exp_q.push_back(s);
                s = lfsr_step(s);
`else
                exp_q.push_back(16'(k));
`endif
            end
        end else begin
            exp_drops++;
        end
    endtask

    task automatic push(input logic [8:0] len, input logic [2:0] pr, input logic [3:0] de);
        bit done = 1'b0;
        @(negedge clk);
        bus.desc_vld   = 1'b1;
        bus.desc_len   = len;
        bus.desc_prior = pr;
        bus.desc_dest  = de;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (bus.desc_rdy) begin
                @(posedge clk);
                last_push_t = $time;
                model_push(len, pr, de);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 bus.desc_vld = 1'b0;
        if (!done) check_val("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int limit);
        int quiet = 0;
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #2;
            if (!busy && !in_frame) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("idle_reached", 32'(ok), 1);
    endtask

    task automatic check_counters();
        check_val("pkt_cnt", pkt_cnt, 32'(exp_frames));
        check_val("drop_cnt", drop_cnt, 32'(exp_drops));
        check_val("sb_empty", exp_q.size(), 0);
    endtask

    // Frame monitor: framing rules plus word-by-word scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            have_eop = 1'b0;
            nwords   = 0;
        end else begin
            ncyc++;
            check_val("excl", 32'((int'(bus.wr_sop) + int'(bus.wr_vld) + int'(bus.wr_eop)) <= 1), 1);
            if (bus.wr_sop) begin
                if (in_frame) check_val("sop_in_frame", 1, 0);
                if (have_eop) check_val("eop_sop_gap", 32'((ncyc - last_eop_cyc) >= 2), 1);
                if (exp_len_q.size() == 0) check_val("unexpected_sop", 1, 0);
                else cur_len = exp_len_q[0];
                in_frame   = 1'b1;
                nwords     = 0;
                sop_cyc    = ncyc;
                sop_count++;
                last_sop_t = $time;
            end else if (bus.wr_vld) begin
                if (!in_frame) check_val("vld_outside", 1, 0);
                else if (exp_q.size() == 0) check_val("extra_word", 1, 0);
                else check_val("word", bus.wr_data, exp_q.pop_front());
                nwords++;
            end else if (bus.wr_eop) begin
                if (!in_frame) check_val("eop_outside", 1, 0);
                else begin
                    check_val("frame_words", nwords, cur_len + 1);
                    check_val("frame_cycles", ncyc - sop_cyc, cur_len + 2);
                    if (exp_len_q.size() != 0) void'(exp_len_q.pop_front());
                end
                in_frame     = 1'b0;
                have_eop     = 1'b1;
                last_eop_cyc = ncyc;
                eop_count++;
                last_eop_t   = $time;
            end else if (in_frame) begin
                check_val("stall", 1, 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_pause_en) bus.pause = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int base;
        bit hit;
        logic [8:0] rl;

        bus.desc_vld = 1'b0; bus.desc_len = '0; bus.desc_prior = '0;
        bus.desc_dest = '0;  bus.pause = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_sop", bus.wr_sop, 0);
        check_val("rst_vld", bus.wr_vld, 0);
        check_val("rst_eop", bus.wr_eop, 0);
        check_val("rst_data", bus.wr_data, 0);
        check_val("rst_rdy", bus.desc_rdy, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_pkt_cnt", pkt_cnt, 0);
        check_val("rst_drop_cnt", drop_cnt, 0);
        check_val("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // Single minimum-length frame with exact latency.
        push(9'd31, 3'd5, 4'd9);
        wait_idle(200);
        check_val("sop_latency", 32'(last_sop_t - last_push_t), 25);
        check_val("eop_latency", 32'(last_eop_t - last_push_t), 355);
        check_counters();

        // Maximum length.
        push(9'd511, 3'd7, 4'd15);
        wait_idle(1000);
        check_val("max_frame_span", 32'(last_eop_t - last_sop_t), 5130);
        check_counters();

        // Illegal lengths are dropped with no frame.
        base = sop_count;
        push(9'd30, 3'd1, 4'd2);
        push(9'd0, 3'd3, 4'd4);
        wait_idle(100);
        check_val("illegal_no_sop", sop_count, base);
        check_counters();

        // Fill FIFO under pause, overflow attempt, then release.
        @(negedge clk); #1 bus.pause = 1'b1;
        repeat (2) @(negedge clk);
        base = sop_count;
        for (int i = 0; i < 4; i++)
            push(9'($urandom_range(31, 60)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        @(negedge clk);
        #1 check_val("full_rdy", bus.desc_rdy, 0);
        bus.desc_vld = 1'b1; bus.desc_len = 9'd40;
        @(posedge clk); #1 bus.desc_vld = 1'b0;
        repeat (20) @(negedge clk);
        check_val("paused_no_sop", sop_count, base);
        check_val("paused_busy", busy, 1);
        #1 bus.pause = 1'b0;
        wait_idle(2000);
        check_val("full_frames", sop_count, base + 4);
        check_val("full_rdy_back", bus.desc_rdy, 1);
        check_counters();

        // Pause raised mid-frame: frame completes, next waits.
        push(9'd100, 3'd2, 4'd6);
        push(9'd40, 3'd4, 4'd1);
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk); #2;
            if (in_frame && nwords >= 20) hit = 1'b1;
        end
        check_val("midpause_reach", 32'(hit), 1);
        bus.pause = 1'b1;
        base = eop_count;
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk); #2;
            if (eop_count != base) hit = 1'b1;
        end
        check_val("midpause_eop", 32'(hit), 1);
        base = sop_count;
        repeat (40) @(negedge clk);
        check_val("midpause_hold", sop_count, base);
        #1 bus.pause = 1'b0;
        wait_idle(500);
        check_val("midpause_next", sop_count, base + 1);
        check_counters();

        // Randomized descriptors with random pause.
        rand_pause_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) rl = 9'($urandom_range(0, 30));
            else rl = 9'($urandom_range(31, 120));
            push(rl, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        rand_pause_en = 1'b0;
        @(negedge clk); #1 bus.pause = 1'b0;
        wait_idle(8000);
        check_counters();

        // Reset in the middle of a frame, with another descriptor queued.
        push(9'd50, 3'd1, 4'd3);
        push(9'd60, 3'd2, 4'd5);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk); #2;
            if (in_frame && nwords >= 11) hit = 1'b1;
        end
        check_val("rst_mid_reach", 32'(hit), 1);
        rst_n = 1'b0;
        #1;
        check_val("rstmid_vld", bus.wr_vld, 0);
        check_val("rstmid_eop", bus.wr_eop, 0);
        check_val("rstmid_rdy", bus.desc_rdy, 1);
        check_val("rstmid_pkt_cnt", pkt_cnt, 0);
        check_val("rstmid_busy", busy, 0);
        exp_q.delete();
        exp_len_q.delete();
        exp_frames = 0;
        exp_drops  = 0;
        base = eop_count;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check_val("rstmid_no_eop", eop_count, base);
        check_val("rstmid_idle", busy, 0);
        check_counters();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
